// File: rtl/instr_fetch_decode.sv
// Fetches a program from instruction memory and decodes each word into the
// flat control word + pipe_en that drive the control pipeline.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, base_addr      begin execution at base_addr (1-cycle pulse)
//   stall                 datapath back-pressure, freezes issue
//   instr_rd_en/addr      instruction memory read request
//   instr_rdata           read data, valid 1 cycle after instr_rd_en
//   ctrl_word, pipe_en    registered control word and advance enable
//   busy, done, err       status: running, end pulse, sticky bad opcode
module instr_fetch_decode #(
  parameter int INSTR_W     = 64,
  parameter int CTRL_W      = 56,
  parameter int ADDR_W      = 12,
  parameter int PIPE_STAGES = 4,
  parameter int NOP_CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               stall,
  output logic               instr_rd_en,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_rdata,
  output logic [CTRL_W-1:0]  ctrl_word,
  output logic               pipe_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int DCNT_W = $clog2(PIPE_STAGES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_NOP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [NOP_CNT_W-1:0] cnt_q, cnt_d;
  logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [INSTR_W-1:0]   skid_q, skid_d;
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic                 pipe_en_q, pipe_en_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [INSTR_W-1:0]   word;
  logic                 word_vld;
  logic [1:0]           op;
  logic [NOP_CNT_W-1:0] nop_n;
  logic                 issue;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 unused_bits;

  // Skid holds a word that came back during a stall; it wins over rdata.
  assign word     = skid_vld_q ? skid_q : instr_rdata;
  assign word_vld = skid_vld_q | rd_pend_q;
  assign op       = word[INSTR_W-1 -: 2];
  assign nop_n    = word[NOP_CNT_W-1:0];

  assign unused_bits = ^word[INSTR_W-3:CTRL_W];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    dcnt_d     = dcnt_q;
    rd_pend_d  = 1'b0;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    ctrl_d     = ctrl_q;
    pipe_en_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    issue      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = pc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          rd_en      = 1'b1;
          rd_addr    = base_addr;
          rd_pend_d  = 1'b1;
          pc_d       = base_addr + ADDR_W'(1);
          err_d      = 1'b0;
          skid_vld_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (stall) begin
          if (rd_pend_q) begin
            skid_vld_d = 1'b1;
            skid_d     = instr_rdata;
          end
        end else if (word_vld) begin
          skid_vld_d = 1'b0;
          pipe_en_d  = 1'b1;
          ctrl_d     = '0;
          unique case (1'b1)
            op == 2'b01: begin
              ctrl_d = word[CTRL_W-1:0];
              issue  = 1'b1;
            end
            op == 2'b00: begin
              // n of 0 or 1 is a single bubble
              if (nop_n <= NOP_CNT_W'(1)) begin
                issue = 1'b1;
              end else begin
                cnt_d   = nop_n - NOP_CNT_W'(1);
                state_d = S_NOP;
              end
            end
            default: begin
              if (op == 2'b11) err_d = 1'b1;
              dcnt_d  = DCNT_W'(PIPE_STAGES);
              state_d = S_DRAIN;
            end
          endcase
        end
      end
      S_NOP: begin
        if (!stall) begin
          pipe_en_d = 1'b1;
          ctrl_d    = '0;
          cnt_d     = cnt_q - NOP_CNT_W'(1);
          if (cnt_q == NOP_CNT_W'(1)) begin
            issue   = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          pipe_en_d = 1'b1;
          ctrl_d    = '0;
          dcnt_d    = dcnt_q - DCNT_W'(1);
          if (dcnt_q == DCNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      rd_en     = 1'b1;
      rd_addr   = pc_q;
      rd_pend_d = 1'b1;
      pc_d      = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      rd_pend_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      ctrl_q     <= '0;
      pipe_en_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      rd_pend_q  <= rd_pend_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      ctrl_q     <= ctrl_d;
      pipe_en_q  <= pipe_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign instr_rd_en = rd_en & ~rst;
  assign instr_addr  = rd_addr;
  assign ctrl_word   = ctrl_q;
  assign pipe_en     = pipe_en_q;
  assign busy        = (state_q != S_IDLE) | done_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode with a control-word scoreboard.
// Memory model returns data one cycle after each read strobe.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic        stall;
  logic        instr_rd_en;
  logic [11:0] instr_addr;
  logic [63:0] instr_rdata = '0;
  logic [55:0] ctrl_word;
  logic        pipe_en;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] mem [0:4095];
  logic [11:0] rd_log [$];
  logic [55:0] exp_q  [$];
  logic [55:0] mon_e;

  instr_fetch_decode dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .stall       (stall),
    .instr_rd_en (instr_rd_en),
    .instr_addr  (instr_addr),
    .instr_rdata (instr_rdata),
    .ctrl_word   (ctrl_word),
    .pipe_en     (pipe_en),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (instr_rd_en) begin
      instr_rdata <= mem[instr_addr];
      rd_log.push_back(instr_addr);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every pipe_en=1 cycle consumes one expected control word.
  always @(negedge clk) begin
    if (pipe_en === 1'b1) begin
      chk("sb_avail", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_ctrl", 64'(ctrl_word), 64'(mon_e));
      end
    end
  end

  function automatic logic [63:0] f_exec(input logic [55:0] p);
    return {2'b01, 6'b0, p};
  endfunction

  function automatic logic [63:0] f_nop(input logic [15:0] n);
    return {2'b00, 46'b0, n};
  endfunction

  function automatic logic [63:0] f_op(input logic [1:0] o);
    return {o, 62'b0};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_bub(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  task automatic go(input logic [11:0] a);
    base_addr = a;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    chk(tag, 64'(done), 64'd1);
    tick();
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  logic [11:0] wexp [3];

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stall     = 1'b0;
    base_addr = '0;
    tick();
    tick();
    chk("rst_ctrl", 64'(ctrl_word), 64'd0);
    chk("rst_pipe_en", 64'(pipe_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_en", 64'(instr_rd_en), 64'd0);
    rst = 1'b0;
    tick();

    // Basic program: 3 EXEC + END, exact cycle timing.
    mem[12'h010] = f_exec(56'hA1);
    mem[12'h011] = f_exec(56'hA2);
    mem[12'h012] = f_exec(56'hA3);
    mem[12'h013] = f_op(2'b10);
    exp_q.push_back(56'hA1);
    exp_q.push_back(56'hA2);
    exp_q.push_back(56'hA3);
    push_bub(5);
    base_addr = 12'h010;
    start     = 1'b1;
    #1 chk("t1_rd_en", 64'(instr_rd_en), 64'd1);
    chk("t1_rd_addr", 64'(instr_addr), 64'h010);
    tick();
    start = 1'b0;
    chk("t1_busy_t1", 64'(busy), 64'd1);
    chk("t1_pe_t1", 64'(pipe_en), 64'd0);
    tick();
    chk("t1_ctrl_t2", 64'(ctrl_word), 64'hA1);
    chk("t1_pe_t2", 64'(pipe_en), 64'd1);
    tick();
    chk("t1_ctrl_t3", 64'(ctrl_word), 64'hA2);
    tick();
    chk("t1_ctrl_t4", 64'(ctrl_word), 64'hA3);
    for (int k = 5; k <= 9; k++) begin
      tick();
      chk($sformatf("t1_bub_pe_t%0d", k), 64'(pipe_en), 64'd1);
      chk($sformatf("t1_bub_ctrl_t%0d", k), 64'(ctrl_word), 64'd0);
      chk($sformatf("t1_nodone_t%0d", k), 64'(done), 64'd0);
    end
    tick();
    chk("t1_done_t10", 64'(done), 64'd1);
    chk("t1_pe_t10", 64'(pipe_en), 64'd0);
    chk("t1_busy_t10", 64'(busy), 64'd1);
    tick();
    chk("t1_busy_t11", 64'(busy), 64'd0);
    chk("t1_done_t11", 64'(done), 64'd0);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // NOP n=3 between two EXECs.
    mem[12'h100] = f_exec(56'h11);
    mem[12'h101] = f_nop(16'd3);
    mem[12'h102] = f_exec(56'h22);
    mem[12'h103] = f_op(2'b10);
    exp_q.push_back(56'h11);
    push_bub(3);
    exp_q.push_back(56'h22);
    push_bub(5);
    go(12'h100);
    wait_done("nop3_done");

    // NOP n=0 acts as a single bubble.
    mem[12'h200] = f_exec(56'h11);
    mem[12'h201] = f_nop(16'd0);
    mem[12'h202] = f_exec(56'h22);
    mem[12'h203] = f_op(2'b10);
    exp_q.push_back(56'h11);
    push_bub(1);
    exp_q.push_back(56'h22);
    push_bub(5);
    go(12'h200);
    wait_done("nop0_done");

    // Two-cycle stall right after the second read is issued.
    mem[12'h300] = f_exec(56'h31);
    mem[12'h301] = f_exec(56'h32);
    mem[12'h302] = f_exec(56'h33);
    mem[12'h303] = f_op(2'b10);
    exp_q.push_back(56'h31);
    exp_q.push_back(56'h32);
    exp_q.push_back(56'h33);
    push_bub(5);
    go(12'h300);
    tick();
    stall = 1'b1;
    chk("st_ctrl_t2", 64'(ctrl_word), 64'h31);
    #1 chk("st_rd_en_t2", 64'(instr_rd_en), 64'd0);
    tick();
    chk("st_pe_t3", 64'(pipe_en), 64'd0);
    chk("st_hold_t3", 64'(ctrl_word), 64'h31);
    #1 chk("st_rd_en_t3", 64'(instr_rd_en), 64'd0);
    tick();
    stall = 1'b0;
    chk("st_pe_t4", 64'(pipe_en), 64'd0);
    chk("st_hold_t4", 64'(ctrl_word), 64'h31);
    tick();
    chk("st_ctrl_t5", 64'(ctrl_word), 64'h32);
    chk("st_pe_t5", 64'(pipe_en), 64'd1);
    wait_done("st_done");

    // Address wrap-around from 0xFFE.
    mem[12'hFFE] = f_exec(56'h41);
    mem[12'hFFF] = f_exec(56'h42);
    mem[12'h000] = f_op(2'b10);
    exp_q.push_back(56'h41);
    exp_q.push_back(56'h42);
    push_bub(5);
    rd_log.delete();
    go(12'hFFE);
    wait_done("wrap_done");
    wexp[0] = 12'hFFE;
    wexp[1] = 12'hFFF;
    wexp[2] = 12'h000;
    chk("wrap_nreads", 64'(rd_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < rd_log.size(); i++)
      chk($sformatf("wrap_addr%0d", i), 64'(rd_log[i]), 64'(wexp[i]));

    // Reserved opcode sets err and drains like END.
    mem[12'h400] = f_exec(56'h51);
    mem[12'h401] = f_op(2'b11);
    exp_q.push_back(56'h51);
    push_bub(5);
    go(12'h400);
    chk("rsv_err_clr0", 64'(err), 64'd0);
    wait_done("rsv_done");
    chk("rsv_err", 64'(err), 64'd1);
    mem[12'h500] = f_exec(56'h61);
    mem[12'h501] = f_op(2'b10);
    exp_q.push_back(56'h61);
    push_bub(5);
    go(12'h500);
    chk("rsv_err_cleared", 64'(err), 64'd0);
    wait_done("rsv_next_done");

    // Reset in the middle of a long NOP.
    mem[12'h600] = f_exec(56'h71);
    mem[12'h601] = f_nop(16'd7);
    mem[12'h602] = f_op(2'b10);
    exp_q.push_back(56'h71);
    push_bub(2);
    go(12'h600);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_ctrl", 64'(ctrl_word), 64'd0);
    chk("mr_pe", 64'(pipe_en), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_err", 64'(err), 64'd0);
    #1 chk("mr_rd_en", 64'(instr_rd_en), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mr_nodone%0d", k), 64'(done), 64'd0);
      chk($sformatf("mr_idle%0d", k), 64'(busy), 64'd0);
    end
    chk("mr_sb_empty", 64'(exp_q.size()), 64'd0);
    mem[12'h700] = f_exec(56'h81);
    mem[12'h701] = f_op(2'b10);
    exp_q.push_back(56'h81);
    push_bub(5);
    go(12'h700);
    tick();
    chk("mr_restart_ctrl", 64'(ctrl_word), 64'h81);
    wait_done("mr_restart_done");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
Upstream neighbour of the pipelined control stage. It sequences a program from the instruction memory and decodes each instruction word into the flat control word and pipe_en that feed the control pipeline. It handles multi-cycle NOPs, datapath stalls and program termination, and it drains the control pipeline before signalling done.

Parameters:
INSTR_W, 64, instruction word width
CTRL_W, 56, control word width; concatenated alu_mode/crossbar_sel/ram/reg fields in package order
ADDR_W, 12, instruction memory address width
PIPE_STAGES, 4, depth of the downstream control pipeline (drain length)
NOP_CNT_W, 16, width of the NOP count field

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
start  input  1  1-cycle pulse: begin execution at base_addr
base_addr  input  ADDR_W  first instruction address
stall  input  1  datapath back-pressure; freezes issue
instr_rd_en  output  1  instruction memory read strobe
instr_addr  output  ADDR_W  instruction memory address
instr_rdata  input  INSTR_W  read data, valid exactly 1 cycle after instr_rd_en
ctrl_word  output  CTRL_W  decoded control word (registered)
pipe_en  output  1  control-pipeline advance enable (registered)
busy  output  1  high from the cycle after start until done
done  output  1  1-cycle pulse at program end
err  output  1  sticky reserved-opcode flag; cleared on start

Behaviour:
- Instruction format: opcode = instr[INSTR_W-1:INSTR_W-2]
  - 00 NOP: n = instr[NOP_CNT_W-1:0] bubbles; n=0 is treated as 1.
  - 01 EXEC: payload = instr[CTRL_W-1:0].
  - 10 END.
  - 11 reserved: sets err, then behaves as END.
- Reset: state=IDLE, pc=0. All outputs 0, and all internal registers (skid valid, counters) cleared at the first clock edge with rst=1. rst overrides start and stall. Reset mid-program aborts with no drain and no done pulse.
- IDLE:
  - start=1 issues a read combinationally in the same cycle (instr_rd_en=1, instr_addr=base_addr), sets pc<=base_addr+1, clears err, and goes to RUN.
  - start while busy is ignored.
- Word source in RUN: the fetched word comes from instr_rdata (1 cycle after a read) or from a 1-entry skid register.
  - Any word returning while stall=1 is captured into the skid.
  - The skid has priority and is consumed on the first non-stall cycle.
  - At most one outstanding read; a read is issued only with stall=0.
- RUN, stall=0, decode word W:
  - EXEC: ctrl_word<=payload, pipe_en<=1; read at pc, pc<=pc+1.
  - NOP: ctrl_word<=0, pipe_en<=1. If n==1, read at pc, pc<=pc+1, stay in RUN. Otherwise cnt<=n-1 and go to NOP.
  - END/reserved: ctrl_word<=0, pipe_en<=1, dcnt<=PIPE_STAGES, go to DRAIN. No further reads are issued.
- NOP state, stall=0: emit a bubble (ctrl_word=0, pipe_en=1) and decrement cnt. In the cycle cnt==1, read at pc, pc<=pc+1, and return to RUN.
- DRAIN state, stall=0: emit a bubble and decrement dcnt. When dcnt==1, go to DONE.
- DONE: done=1 for one cycle, pipe_en<=0, busy drops, go to IDLE.
- Stall (RUN/NOP/DRAIN): pipe_en<=0 and ctrl_word held at its previous value. Counters, pc and state are frozen, and no read is issued. Outputs are registered, so stall at cycle t is visible as pipe_en=0 at t+1.
- Latency: start at T → first EXEC appears on ctrl_word with pipe_en=1 at T+2. Steady-state throughput is 1 EXEC per cycle.
- Wrap-around: pc increments modulo 2^ADDR_W (4095→0); no error.
- Total pipe_en=1 cycles after END decode = 1 + PIPE_STAGES.

Test Plan:
- 3×EXEC(0xA1,0xA2,0xA3)+END at base 0x010, start at T → ctrl_word 0xA1/0xA2/0xA3 at T+2..T+4, then 5 bubbles with pipe_en=1, done at T+10, busy low from T+11.
- NOP n=3 between EXEC 0x11 and 0x22 → exactly 3 zero-control cycles with pipe_en=1 between them. Repeat with n=0 → exactly 1 bubble.
- Stall for 2 cycles the cycle after a read is issued → word captured in skid, pipe_en=0 for 2 cycles with ctrl_word held, then the next EXEC issues with nothing lost or duplicated.
- Program at base 0xFFE (EXEC, EXEC, END at 0x000) → addresses 0xFFE, 0xFFF, 0x000 read in order, done asserted.
- Reserved opcode 11 → err=1, drain of 5 bubbles, done. The next start clears err.
- rst asserted mid-NOP (cnt=5) → next cycle all outputs 0 and state IDLE, no done pulse. A subsequent start executes normally.
